// File: rtl/cache_def.sv
// Shared cache/memory interface types plus the memory-arbiter state encoding.
package cache_def;
  localparam int LINE_W        = 128;
  localparam int ARB_MAX_PORTS = 4;

  typedef struct packed {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_type;
endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first set bit of pend at or after rr_ptr, modulo N_PORTS.
module rr_picker #(
  parameter  int N_PORTS = 2,
  localparam int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] pend,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               any_pend
);
  localparam logic [PTR_W:0] NP = (PTR_W+1)'(N_PORTS);

  logic [PTR_W:0] idx;

  // Scan from the farthest offset down so the nearest pending port wins last.
  always_comb begin
    sel      = '0;
    idx      = '0;
    any_pend = |pend;
    for (int i = N_PORTS-1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (pend[idx[PTR_W-1:0]]) sel = idx[PTR_W-1:0];
    end
  end
endmodule

// File: rtl/dm_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_PORTS cache controllers.
// Optional ARB_WB_LOCK_EN: a write-back keeps the grant for its same-cycle refill request.
module dm_mem_arbiter
  import cache_def::*;
#(
  parameter  int N_PORTS = 2,
  localparam int PTR_W   = $clog2(N_PORTS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  mem_req_type  [N_PORTS-1:0]  port_req_i,
  output mem_data_type [N_PORTS-1:0]  port_rsp_o,
  output mem_req_type                 mem_req_o,
  input  mem_data_type                mem_rsp_i,
  output logic                        busy_o,
  output logic [PTR_W-1:0]            grant_o,
  output logic [N_PORTS-1:0]          overrun_o
);
  arb_state_type             state_q, state_d;
  logic [PTR_W-1:0]          rr_q, rr_d, grant_d, nxt_ptr, pick_ptr, sel;
  logic [N_PORTS-1:0]        pend_q, pick_pend, done, cap;
  mem_req_type [N_PORTS-1:0] req_q;
  mem_req_type               hold_q;
  logic                      cmpl, any_pend, lock_take;

  assign busy_o  = (state_q == ARB_BUSY);
  assign cmpl    = busy_o && mem_rsp_i.ready;
  assign nxt_ptr = (grant_o == PTR_W'(N_PORTS-1)) ? '0 : grant_o + 1'b1;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign done[p] = cmpl && (grant_o == PTR_W'(p));
    // A finishing port may reload its buffer in the same cycle (write-back -> allocate).
    assign cap[p]  = port_req_i[p].valid && (!pend_q[p] || done[p]);
    assign port_rsp_o[p].ready = done[p];
    assign port_rsp_o[p].data  = busy_o ? mem_rsp_i.data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q    <= '0;
      req_q     <= '0;
      overrun_o <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (cap[p]) begin
          pend_q[p] <= 1'b1;
          req_q[p]  <= port_req_i[p];
        end else if (done[p]) begin
          pend_q[p] <= 1'b0;
        end
        if (port_req_i[p].valid && pend_q[p] && !done[p]) overrun_o[p] <= 1'b1;
      end
    end
  end

`ifdef ARB_WB_LOCK_EN
  logic lock_q;
  // lock_q marks a locked follow-on so a second write-back cannot chain the lock.
  assign lock_take = cmpl && req_q[grant_o].rw && cap[grant_o] && !lock_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   lock_q <= 1'b0;
    else if (cmpl) lock_q <= lock_take;
  end
`else
  assign lock_take = 1'b0;
`endif

  // While busy, look for the next owner among the other ports, starting after the current one.
  always_comb begin
    pick_pend = pend_q;
    pick_ptr  = rr_q;
    if (busy_o) begin
      pick_pend[grant_o] = 1'b0;
      pick_ptr           = nxt_ptr;
    end
  end

  rr_picker #(.N_PORTS(N_PORTS)) u_pick (
    .pend     (pick_pend),
    .rr_ptr   (pick_ptr),
    .sel      (sel),
    .any_pend (any_pend)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_o;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: if (any_pend) begin
        state_d = ARB_BUSY;
        grant_d = sel;
      end
      ARB_BUSY: if (mem_rsp_i.ready && !lock_take) begin
        rr_d = nxt_ptr;
        if (any_pend) grant_d = sel;
        else          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_o <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      rr_q    <= rr_d;
      if (busy_o) hold_q <= req_q[grant_o];
    end
  end

  // Idle keeps the last transfer's addr/data/rw on the bus with valid dropped.
  always_comb begin
    if (busy_o) begin
      mem_req_o       = req_q[grant_o];
      mem_req_o.valid = 1'b1;
    end else begin
      mem_req_o       = hold_q;
      mem_req_o.valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Self-checking bench for dm_mem_arbiter (2 ports): directed table, corner sequences, random vs model.
module tb_dm_mem_arbiter;
  import cache_def::*;
  localparam int N = 2;
`ifdef ARB_WB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam logic [127:0] A5 = {16{8'hA5}};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  mem_req_type  [N-1:0] port_req;
  mem_data_type [N-1:0] port_rsp;
  mem_req_type          mem_req;
  mem_data_type         mem_rsp;
  logic                 busy;
  logic                 grant;
  logic [N-1:0]         overrun;

  dm_mem_arbiter #(.N_PORTS(N)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .port_req_i(port_req), .port_rsp_o(port_rsp),
    .mem_req_o(mem_req), .mem_rsp_i(mem_rsp), .busy_o(busy), .grant_o(grant),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pdat(input logic [31:0] a);
    return {4{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [1:0] rdy_vec();
    return {port_rsp[1].ready, port_rsp[0].ready};
  endfunction

  // One cycle: drive inputs just after the edge, then sample before the falling edge.
  task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [1:0] rw, input logic mrdy);
    @(posedge clk); #1;
    port_req = '0;
    if (v[0]) port_req[0] = '{addr: a0, data: pdat(a0), rw: rw[0], valid: 1'b1};
    if (v[1]) port_req[1] = '{addr: a1, data: pdat(a1), rw: rw[1], valid: 1'b1};
    mem_rsp.ready = mrdy;
    mem_rsp.data  = A5;
    #3;
  endtask

  task automatic chk_bus(input string nm, input logic g, input logic [31:0] a, input logic rw);
    chk({nm, ".busy"},  256'(busy), 256'(1'b1));
    chk({nm, ".grant"}, 256'(grant), 256'(g));
    chk({nm, ".valid"}, 256'(mem_req.valid), 256'(1'b1));
    chk({nm, ".addr"},  256'(mem_req.addr), 256'(a));
    chk({nm, ".data"},  256'(mem_req.data), 256'(pdat(a)));
    chk({nm, ".rw"},    256'(mem_req.rw), 256'(rw));
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0, a1;
    logic        mrdy;
    logic        b, g, mv;
    logic [31:0] ma;
    logic [1:0]  rdy;
  } vec_t;
  vec_t tbl[19];

  // reference model state
  bit          m_pend[N];
  mem_req_type m_req[N];
  bit          m_busy, m_lock;
  int          m_own, m_rr;
  mem_req_type m_last;
  logic [N-1:0] m_ovr;

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          v      a0            a1           rdy  busy g  mv  maddr          rdy
    tbl[0]  = '{2'b11, 32'h100,      32'h200,     0,   0,   0, 0,  32'h0,         2'b00};
    tbl[1]  = '{2'b00, 32'h0,        32'h0,       0,   0,   0, 0,  32'h0,         2'b00};
    tbl[2]  = '{2'b00, 32'h0,        32'h0,       0,   1,   0, 1,  32'h100,       2'b00};
    tbl[3]  = '{2'b00, 32'h0,        32'h0,       1,   1,   0, 1,  32'h100,       2'b01};
    tbl[4]  = '{2'b00, 32'h0,        32'h0,       0,   1,   1, 1,  32'h200,       2'b00};
    tbl[5]  = '{2'b00, 32'h0,        32'h0,       1,   1,   1, 1,  32'h200,       2'b10};
    tbl[6]  = '{2'b01, 32'h0000_1230, 32'h0,      0,   0,   1, 0,  32'h200,       2'b00};
    tbl[7]  = '{2'b00, 32'h0,        32'h0,       0,   0,   1, 0,  32'h200,       2'b00};
    tbl[8]  = '{2'b00, 32'h0,        32'h0,       0,   1,   0, 1,  32'h0000_1230, 2'b00};
    tbl[9]  = '{2'b00, 32'h0,        32'h0,       0,   1,   0, 1,  32'h0000_1230, 2'b00};
    tbl[10] = '{2'b00, 32'h0,        32'h0,       0,   1,   0, 1,  32'h0000_1230, 2'b00};
    tbl[11] = '{2'b00, 32'h0,        32'h0,       1,   1,   0, 1,  32'h0000_1230, 2'b01};
    tbl[12] = '{2'b11, 32'h300,      32'h400,     1,   0,   0, 0,  32'h0000_1230, 2'b00};
    tbl[13] = '{2'b00, 32'h0,        32'h0,       0,   0,   0, 0,  32'h0000_1230, 2'b00};
    tbl[14] = '{2'b00, 32'h0,        32'h0,       0,   1,   1, 1,  32'h400,       2'b00};
    tbl[15] = '{2'b00, 32'h0,        32'h0,       1,   1,   1, 1,  32'h400,       2'b10};
    tbl[16] = '{2'b00, 32'h0,        32'h0,       0,   1,   0, 1,  32'h300,       2'b00};
    tbl[17] = '{2'b00, 32'h0,        32'h0,       1,   1,   0, 1,  32'h300,       2'b01};
    tbl[18] = '{2'b00, 32'h0,        32'h0,       0,   0,   0, 0,  32'h300,       2'b00};

    port_req = '0;
    mem_rsp  = '{data: A5, ready: 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy",    256'(busy), 256'(1'b0));
    chk("reset.grant",   256'(grant), 256'(1'b0));
    chk("reset.mem_req", 256'(mem_req), 256'(0));
    chk("reset.overrun", 256'(overrun), 256'(0));
    chk("reset.rsp",     256'(port_rsp), 256'(0));
    rst_ni = 1'b1;

    // directed table: simultaneous pair, single request, stray ready, reversed pair
    for (int k = 0; k < 19; k++) begin
      cyc(tbl[k].v, tbl[k].a0, tbl[k].a1, 2'b00, tbl[k].mrdy);
      chk($sformatf("tbl%0d.busy", k),  256'(busy), 256'(tbl[k].b));
      chk($sformatf("tbl%0d.grant", k), 256'(grant), 256'(tbl[k].g));
      chk($sformatf("tbl%0d.valid", k), 256'(mem_req.valid), 256'(tbl[k].mv));
      chk($sformatf("tbl%0d.addr", k),  256'(mem_req.addr), 256'(tbl[k].ma));
      chk($sformatf("tbl%0d.rdy", k),   256'(rdy_vec()), 256'(tbl[k].rdy));
      for (int p = 0; p < N; p++)
        if (tbl[k].rdy[p]) chk($sformatf("tbl%0d.rdata%0d", k, p), 256'(port_rsp[p].data), 256'(A5));
    end

    // write-back then refill on port1 while port0 waits
    cyc(2'b10, 32'h0, 32'h00AB_C010, 2'b10, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(2'b01, 32'h0000_5000, 32'h0, 2'b00, 1'b0);
    chk_bus("wb.c2", 1'b1, 32'h00AB_C010, 1'b1);
    cyc(2'b10, 32'h0, 32'h0001_2010, 2'b00, 1'b1);
    chk("wb.c3.rdy", 256'(rdy_vec()), 256'(2'b10));
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk_bus("wb.c4", LOCK ? 1'b1 : 1'b0, LOCK ? 32'h0001_2010 : 32'h0000_5000, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
    chk("wb.c5.rdy", 256'(rdy_vec()), 256'(LOCK ? 2'b10 : 2'b01));
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk_bus("wb.c6", LOCK ? 1'b0 : 1'b1, LOCK ? 32'h0000_5000 : 32'h0001_2010, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("wb.idle", 256'(busy), 256'(1'b0));

    // overrun: second pulse on port0 while its first request is outstanding
    chk("ovr.before", 256'(overrun), 256'(0));
    cyc(2'b01, 32'h0000_7000, 32'h0, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk_bus("ovr.c2", 1'b0, 32'h0000_7000, 1'b0);
    cyc(2'b01, 32'h0000_7777, 32'h0, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("ovr.flag", 256'(overrun), 256'(2'b01));
    chk_bus("ovr.c4", 1'b0, 32'h0000_7000, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
    chk("ovr.rdy", 256'(rdy_vec()), 256'(2'b01));
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("ovr.idle", 256'(busy), 256'(1'b0));
    chk("ovr.sticky", 256'(overrun), 256'(2'b01));

    // reset in the middle of a transfer
    cyc(2'b10, 32'h0, 32'h0000_8000, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("rst.busy_before", 256'(busy), 256'(1'b1));
    rst_ni = 1'b0;
    #1;
    chk("rst.busy",    256'(busy), 256'(1'b0));
    chk("rst.grant",   256'(grant), 256'(1'b0));
    chk("rst.mem_req", 256'(mem_req), 256'(0));
    chk("rst.overrun", 256'(overrun), 256'(0));
    chk("rst.rsp",     256'(port_rsp), 256'(0));
    @(posedge clk); #1;
    rst_ni = 1'b1;
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
    chk("rst.late_rdy", 256'(rdy_vec()), 256'(2'b00));
    cyc(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    chk("rst.idle", 256'(busy), 256'(1'b0));

    // random traffic against the reference model, starting from a fresh reset
    port_req = '0;
    mem_rsp  = '0;
    rst_ni   = 1'b0;
    #2;
    rst_ni   = 1'b1;
    for (int p = 0; p < N; p++) begin
      m_pend[p] = 1'b0;
      m_req[p]  = '0;
    end
    m_busy = 1'b0; m_lock = 1'b0; m_own = 0; m_rr = 0; m_last = '0; m_ovr = '0;

    for (int c = 0; c < 800; c++) begin
      mem_req_type exp_mem;
      bit done[N];
      bit cap[N];
      bit found, lk;
      @(posedge clk); #1;
      for (int p = 0; p < N; p++)
        port_req[p] = '{addr: $urandom, data: {$urandom, $urandom, $urandom, $urandom},
                        rw: 1'($urandom_range(1)), valid: ($urandom_range(2) == 0)};
      mem_rsp = '{data: {$urandom, $urandom, $urandom, $urandom}, ready: ($urandom_range(2) == 0)};
      #3;

      exp_mem = m_busy ? m_req[m_own] : m_last;
      exp_mem.valid = m_busy;
      chk("rnd.mem_req", 256'(mem_req), 256'(exp_mem));
      chk("rnd.busy",    256'(busy), 256'(m_busy));
      chk("rnd.grant",   256'(grant), 256'(m_own));
      chk("rnd.overrun", 256'(overrun), 256'(m_ovr));
      for (int p = 0; p < N; p++) begin
        done[p] = m_busy && mem_rsp.ready && (m_own == p);
        chk($sformatf("rnd.rdy%0d", p), 256'(port_rsp[p].ready), 256'(done[p]));
        if (done[p]) chk($sformatf("rnd.rdata%0d", p), 256'(port_rsp[p].data), 256'(mem_rsp.data));
        cap[p] = port_req[p].valid && (!m_pend[p] || done[p]);
        if (port_req[p].valid && m_pend[p] && !done[p]) m_ovr[p] = 1'b1;
      end

      if (m_busy) m_last = m_req[m_own];
      if (!m_busy) begin
        found = 1'b0;
        for (int i = 0; i < N; i++)
          if (!found && m_pend[(m_rr + i) % N]) begin
            m_own  = (m_rr + i) % N;
            m_busy = 1'b1;
            found  = 1'b1;
          end
      end else if (mem_rsp.ready) begin
        lk = LOCK && m_req[m_own].rw && cap[m_own] && !m_lock;
        if (lk) m_lock = 1'b1;
        else begin
          int prev;
          m_lock = 1'b0;
          prev   = m_own;
          m_rr   = (m_own + 1) % N;
          found  = 1'b0;
          for (int i = 0; i < N; i++)
            if (!found && ((m_rr + i) % N) != prev && m_pend[(m_rr + i) % N]) begin
              m_own = (m_rr + i) % N;
              found = 1'b1;
            end
          if (!found) m_busy = 1'b0;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (cap[p]) begin
          m_pend[p] = 1'b1;
          m_req[p]  = port_req[p];
        end else if (done[p]) begin
          m_pend[p] = 1'b0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
